serial_link_phy_tx_ser: RTL and testbench
=========================================

SERIAL_LINK_PHY_TX_SER -- requirements
Module: serial_link_phy_tx_ser

Interface
REQ-001 Parameter NumChannels, default 1: independent TX channels, each with its own lanes and forwarded clock.
REQ-002 Parameter NumLanes, default 8: data wires per channel.
REQ-003 Parameter SerRatio, default 2: slots per beat (1, 2, 4 or 8); beat width per channel W = NumLanes*SerRatio.
REQ-004 Parameter MaxClkDiv, default 32: maximum divider; config width CW = $clog2(MaxClkDiv)+1.
REQ-005 clk_i  in  1  single system clock; all logic is on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 clk_div_i  in  CW  clk_i cycles per slot.
REQ-008 clk_shift_start_i  in  CW  counter value of the first forwarded-clock edge within a slot.
REQ-009 clk_shift_end_i  in  CW  counter value of the SDR falling edge within a slot.
REQ-010 ddr_mode_i  in  1  1 = DDR forwarded clock, 0 = SDR.
REQ-011 chan_en_i  in  NumChannels  per-channel enable.
REQ-012 train_en_i  in  1  request for the training pattern.
REQ-013 data_i  in  NumChannels*W  beat; channel c occupies bits [(c+1)*W-1 : c*W].
REQ-014 valid_i / ready_o  in / out  1  beat handshake; transfer when both are high on a clk_i edge.
REQ-015 rcv_clk_o  out  NumChannels  forwarded source-synchronous clocks.
REQ-016 lanes_o  out  NumChannels*NumLanes  serial lane outputs.
REQ-017 busy_o  out  1  high in DATA or TRAIN.
REQ-018 beat_cnt_o  out  16  count of data beats accepted, wrapping.

Function
REQ-019 States: IDLE, DATA, TRAIN. Slot counter cnt runs 0..div-1. Slot index slot runs 0..SerRatio-1.
REQ-020 Beat boundary: in IDLE, or in DATA/TRAIN when cnt==div-1 and slot==SerRatio-1.
REQ-021 At a beat boundary the next state is chosen in this priority order: TRAIN if train_en_i; else DATA if valid_i; else IDLE.
REQ-022 ready_o = valid_i & beat boundary & !train_en_i, as a combinational output; training starves data.
REQ-023 On acceptance: data_i, clk_div_i, clk_shift_start_i, clk_shift_end_i, ddr_mode_i and chan_en_i are latched; cnt and slot are cleared.
REQ-024 Config inputs are used only in their latched form; a mid-beat change takes effect at the next beat.
REQ-025 A latched div below 2 is clamped to 2.
REQ-026 A shift value >= div never matches, so the corresponding edge is suppressed.
REQ-027 Lanes in DATA: lanes_o for channel c during slot s = latched bits [c*W + (s+1)*NumLanes-1 : c*W + s*NumLanes]. Slot 0 is sent first.
REQ-028 Lanes in TRAIN: all lanes are 1 in even slots and 0 in odd slots.
REQ-029 lanes_o and rcv_clk_o are registered. The first slot of an accepted beat appears on the clk_i edge after acceptance, so latency is 1 cycle.
REQ-030 SDR forwarded clock (ddr_mode 0): rcv_clk_o goes to 1 when cnt==shift_start and to 0 when cnt==shift_end, in every slot.
REQ-031 DDR forwarded clock (ddr_mode 1): rcv_clk_o toggles when cnt==shift_start, once per slot; shift_end is ignored.
REQ-032 In IDLE, rcv_clk_o = 0 and lanes_o = 0.
REQ-033 When the FSM enters IDLE from DATA or TRAIN, rcv_clk_o and lanes_o are forced to 0 on that same edge.
REQ-034 A disabled channel (latched chan_en bit 0) holds rcv_clk_o = 0 and lanes_o = 0 in every state.
REQ-035 Back-to-back beats run with no idle cycle; cnt and slot wrap to 0 and the DDR clock phase carries on without a reset.
REQ-036 beat_cnt_o increments by 1 on each accepted beat and wraps 0xFFFF -> 0; TRAIN beats are not counted.
REQ-037 busy_o = (state != IDLE).

Reset
REQ-038 When rst_i is asserted, at any time including mid-beat, the following are cleared immediately: state to IDLE, cnt, slot, beat_cnt_o, all latches, rcv_clk_o and lanes_o.
REQ-039 After rst_i is released, ready_o follows REQ-022 from IDLE.

Verification
Bench configuration: NumChannels=2, NumLanes=4, SerRatio=2, div=4, start=1, end=3.
REQ-040 DDR beat: chan_en=11, data_i=0xA5_3C, valid held 1 cycle -> channel 0 lanes = 0xC then 0x3; channel 1 lanes = 0x5 then 0xA; rcv_clk_o toggles at cycles 2 and 6 after acceptance; ready_o high again at cycle 8.
REQ-041 SDR, two back-to-back beats -> 16 busy cycles with no gap; rcv_clk_o high for counts 1-2 of every slot; beat_cnt_o = 2.
REQ-042 train_en_i=1 while valid_i=1 -> ready_o stays 0; lanes show 0xF,0x0 alternating per slot; beat_cnt_o unchanged; data is accepted at the first boundary after train_en_i drops.
REQ-043 clk_div_i=1 and shift_start=5 -> div is clamped to 2 and the forwarded clock stays at 0; chan_en=01 -> channel 1 outputs are 0 throughout.
REQ-044 rst_i pulsed mid-slot during DATA -> all outputs are 0 asynchronously; the next beat starts cleanly with slot 0 first.

Source files
------------

// File: rtl/serial_link_phy_tx_ser.sv
// rtl/serial_link_phy_tx_ser.sv - multi-channel lane serializer with forwarded source-synchronous clock
module serial_link_phy_tx_ser #(
    parameter int NumChannels = 1,
    parameter int NumLanes    = 8,
    parameter int SerRatio    = 2,
    parameter int MaxClkDiv   = 32,
    localparam int W          = NumLanes * SerRatio,
    localparam int CW         = $clog2(MaxClkDiv) + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [CW-1:0]                   clk_div_i,
    input  logic [CW-1:0]                   clk_shift_start_i,
    input  logic [CW-1:0]                   clk_shift_end_i,
    input  logic                            ddr_mode_i,
    input  logic [NumChannels-1:0]          chan_en_i,
    input  logic                            train_en_i,
    input  logic [NumChannels*W-1:0]        data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [NumChannels-1:0]          rcv_clk_o,
    output logic [NumChannels*NumLanes-1:0] lanes_o,
    output logic                            busy_o,
    output logic [15:0]                     beat_cnt_o
);

    localparam int SW = (SerRatio > 1) ? $clog2(SerRatio) : 1;
    localparam logic [SW-1:0] LastSlot = SW'(SerRatio - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TRAIN = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;

    logic [CW-1:0]                   r_cnt;
    logic [SW-1:0]                   r_slot;

    // Beat-level latched configuration; live inputs never drive the outputs directly
    logic [CW-1:0]                   r_div;
    logic [CW-1:0]                   r_start;
    logic [CW-1:0]                   r_end;
    logic                            r_ddr;
    logic [NumChannels-1:0]          r_en;
    logic [NumChannels*W-1:0]        r_data;
    logic [15:0]                     r_beat_cnt;

    logic [NumChannels-1:0]          r_rcv;
    logic [NumChannels*NumLanes-1:0] r_lanes;

    logic                            w_cnt_last;
    logic                            w_slot_last;
    logic                            w_boundary;
    logic                            w_accept;
    logic                            w_beat_start;
    logic [CW-1:0]                   w_div_clamped;
    logic [NumChannels-1:0]          w_rcv_next;
    logic [NumChannels*NumLanes-1:0] w_lanes_next;

    assign w_cnt_last    = (r_cnt == (r_div - CW'(1)));
    assign w_slot_last   = (r_slot == LastSlot);
    assign w_boundary    = (r_state == ST_IDLE) || (w_cnt_last && w_slot_last);
    assign w_accept      = valid_i && w_boundary && !train_en_i;
    assign w_beat_start  = w_boundary && (w_state_next != ST_IDLE);
    // A divider below 2 would leave no room for both clock edges in a slot
    assign w_div_clamped = (clk_div_i < CW'(2)) ? CW'(2) : clk_div_i;

    assign ready_o    = w_accept;
    assign busy_o     = (r_state != ST_IDLE);
    assign beat_cnt_o = r_beat_cnt;
    assign rcv_clk_o  = r_rcv;
    assign lanes_o    = r_lanes;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state is only re-evaluated at beat boundaries; training outranks data
    always_comb begin
        w_state_next = r_state;
        if (w_boundary) begin
            if (train_en_i) begin
                w_state_next = ST_TRAIN;
            end else if (valid_i) begin
                w_state_next = ST_DATA;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
    end

    // Slot counter and slot index; both restart at every beat boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (w_boundary) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (r_state != ST_IDLE) begin
            if (w_cnt_last) begin
                r_cnt  <= '0;
                r_slot <= r_slot + SW'(1);
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    // Latch timing/enable config for every beat (data or training), payload only on acceptance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div      <= '0;
            r_start    <= '0;
            r_end      <= '0;
            r_ddr      <= 1'b0;
            r_en       <= '0;
            r_data     <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_beat_start) begin
                r_div   <= w_div_clamped;
                r_start <= clk_shift_start_i;
                r_end   <= clk_shift_end_i;
                r_ddr   <= ddr_mode_i;
                r_en    <= chan_en_i;
            end
            if (w_accept) begin
                r_data     <= data_i;
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
        end
    end

    // Next lane/clock values from the current slot; forced low in or on entry to IDLE
    always_comb begin
        w_lanes_next = '0;
        w_rcv_next   = '0;
        if ((r_state != ST_IDLE) && (w_state_next != ST_IDLE)) begin
            for (int c = 0; c < NumChannels; c++) begin
                if (r_en[c]) begin
                    if (r_state == ST_TRAIN) begin
                        w_lanes_next[c*NumLanes +: NumLanes] = {NumLanes{~r_slot[0]}};
                    end else begin
                        w_lanes_next[c*NumLanes +: NumLanes] =
                            r_data[c*W + int'(r_slot)*NumLanes +: NumLanes];
                    end
                    // A shift value >= div is never reached by r_cnt, suppressing that edge
                    if (r_ddr) begin
                        w_rcv_next[c] = (r_cnt == r_start) ? ~r_rcv[c] : r_rcv[c];
                    end else if (r_cnt == r_start) begin
                        w_rcv_next[c] = 1'b1;
                    end else if (r_cnt == r_end) begin
                        w_rcv_next[c] = 1'b0;
                    end else begin
                        w_rcv_next[c] = r_rcv[c];
                    end
                end
            end
        end
    end

    // Output registers give the one-cycle lane and clock latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lanes <= '0;
            r_rcv   <= '0;
        end else begin
            r_lanes <= w_lanes_next;
            r_rcv   <= w_rcv_next;
        end
    end

endmodule

// File: tb/tb_serial_link_phy_tx_ser.sv
// tb/tb_serial_link_phy_tx_ser.sv - self-checking bench for serial_link_phy_tx_ser
module tb_serial_link_phy_tx_ser;

    localparam int NC  = 2;
    localparam int NL  = 4;
    localparam int SR  = 2;
    localparam int MCD = 32;
    localparam int CW  = $clog2(MCD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] clk_div_i = 6'd4;
    logic [CW-1:0] start_i = 6'd1;
    logic [CW-1:0] end_i = 6'd3;
    logic          ddr_i = 1'b0;
    logic [NC-1:0] en_i = 2'b11;
    logic          train_i = 1'b0;
    logic [15:0]   data_i = 16'h0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [NC-1:0] rcv_clk_o;
    logic [7:0]    lanes_o;
    logic          busy_o;
    logic [15:0]   beat_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    serial_link_phy_tx_ser #(
        .NumChannels(NC), .NumLanes(NL), .SerRatio(SR), .MaxClkDiv(MCD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clk_div_i(clk_div_i),
        .clk_shift_start_i(start_i), .clk_shift_end_i(end_i),
        .ddr_mode_i(ddr_i), .chan_en_i(en_i), .train_en_i(train_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .rcv_clk_o(rcv_clk_o), .lanes_o(lanes_o), .busy_o(busy_o),
        .beat_cnt_o(beat_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat-level model: a beat is div*SR cycles indexed by t; slot = t/div, cnt = t%div
    int         m_mode = 0;   // 0 idle, 1 data, 2 train
    int         m_t = 0;
    int         m_div = 2;
    int         m_start = 0;
    int         m_end = 0;
    bit         m_ddr = 1'b0;
    bit [1:0]   m_en = 2'b00;
    bit [15:0]  m_data = 16'h0;
    bit [7:0]   m_lanes = 8'h0;
    bit [1:0]   m_rcv = 2'b00;
    bit [15:0]  m_bcnt = 16'h0;

    function automatic bit m_bnd();
        return (m_mode == 0) || (m_t == m_div * SR - 1);
    endfunction

    task automatic model_step();
        int       nmode;
        int       slot;
        int       cnt;
        bit       bnd;
        bit [7:0] nl;
        bit [1:0] nr;
        bnd   = m_bnd();
        nmode = m_mode;
        if (bnd) nmode = train_i ? 2 : (valid_i ? 1 : 0);
        nl = 8'h0;
        nr = 2'b00;
        if (m_mode != 0 && nmode != 0) begin
            slot = m_t / m_div;
            cnt  = m_t % m_div;
            for (int c = 0; c < NC; c++) begin
                if (m_en[c]) begin
                    if (m_mode == 2) nl[c*4 +: 4] = (slot % 2 == 0) ? 4'hF : 4'h0;
                    else             nl[c*4 +: 4] = m_data[c*8 + slot*4 +: 4];
                    if (m_ddr)                nr[c] = (cnt == m_start) ? ~m_rcv[c] : m_rcv[c];
                    else if (cnt == m_start)  nr[c] = 1'b1;
                    else if (cnt == m_end)    nr[c] = 1'b0;
                    else                      nr[c] = m_rcv[c];
                end
            end
        end
        if (bnd && nmode != 0) begin
            m_t     = 0;
            m_div   = (clk_div_i < 2) ? 2 : int'(clk_div_i);
            m_start = int'(start_i);
            m_end   = int'(end_i);
            m_ddr   = ddr_i;
            m_en    = en_i;
            if (nmode == 1) begin
                m_data = data_i;
                m_bcnt = m_bcnt + 16'd1;
            end
        end else if (m_mode != 0) begin
            m_t = m_t + 1;
        end
        m_mode  = nmode;
        m_lanes = nl;
        m_rcv   = nr;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_t = 0; m_div = 2; m_start = 0; m_end = 0; m_ddr = 1'b0;
            m_en = 2'b00; m_data = 16'h0; m_lanes = 8'h0; m_rcv = 2'b00; m_bcnt = 16'h0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("cmp_lanes", 32'(lanes_o), 32'(m_lanes));
        chk("cmp_rcv", 32'(rcv_clk_o), 32'(m_rcv));
        chk("cmp_busy", 32'(busy_o), 32'(m_mode != 0));
        chk("cmp_bcnt", 32'(beat_cnt_o), 32'(m_bcnt));
        chk("cmp_ready", 32'(ready_o), 32'(valid_i & m_bnd() & ~train_i));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] ddr_l [9] = '{8'h00, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'hA3, 8'hA3, 8'hA3, 8'h00};
    logic [1:0] ddr_r [9] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    logic       ddr_b [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int busy_n;
        int rcv_n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_lanes", 32'(lanes_o), 32'h0);
        chk("rst_rcv", 32'(rcv_clk_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_bcnt", 32'(beat_cnt_o), 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;

        // DDR single beat
        ddr_i = 1'b1; data_i = 16'hA53C; valid_i = 1'b1;
        @(posedge clk); #2 valid_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("ddr_lanes_k%0d", k), 32'(lanes_o), 32'(ddr_l[k]));
            chk($sformatf("ddr_rcv_k%0d", k), 32'(rcv_clk_o), 32'(ddr_r[k]));
            chk($sformatf("ddr_busy_k%0d", k), 32'(busy_o), 32'(ddr_b[k]));
        end
        chk("ddr_bcnt", 32'(beat_cnt_o), 32'd1);

        // SDR, two back-to-back beats
        @(posedge clk); #2;
        ddr_i = 1'b0; data_i = 16'h1234; valid_i = 1'b1;
        @(posedge clk); #2 data_i = 16'h5678;
        busy_n = 0;
        rcv_n  = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            busy_n += int'(busy_o);
            rcv_n  += int'(rcv_clk_o[0]);
            if (k == 7) chk("sdr_ready_k7", 32'(ready_o), 32'h1);
            if (k == 9) chk("sdr_lanes_k9", 32'(lanes_o), 32'h68);
            if (k == 8) begin
                chk("sdr_lanes_k8", 32'(lanes_o), 32'h13);
                #1 valid_i = 1'b0;
            end
        end
        chk("sdr_busy_cycles", 32'(busy_n), 32'd16);
        chk("sdr_rcv_high", 32'(rcv_n), 32'd8);
        chk("sdr_bcnt", 32'(beat_cnt_o), 32'd3);

        // Training starves data
        @(posedge clk); #2;
        train_i = 1'b1; valid_i = 1'b1; data_i = 16'hBEEF;
        @(posedge clk); #2;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k <= 14) chk($sformatf("trn_ready_k%0d", k), 32'(ready_o), 32'h0);
            if (k == 15) begin
                chk("trn_ready_k15", 32'(ready_o), 32'h1);
                chk("trn_bcnt_k15", 32'(beat_cnt_o), 32'd3);
            end
            if ((k >= 1 && k <= 4) || (k >= 9 && k <= 12))
                chk($sformatf("trn_lanes_k%0d", k), 32'(lanes_o), 32'hFF);
            if (k >= 5 && k <= 8)
                chk($sformatf("trn_lanes_k%0d", k), 32'(lanes_o), 32'h00);
            if (k == 10) #1 train_i = 1'b0;
            if (k == 16) begin
                chk("trn_bcnt_k16", 32'(beat_cnt_o), 32'd4);
                #1 valid_i = 1'b0;
            end
        end
        repeat (10) @(posedge clk);
        #2;

        // Divider clamp, suppressed edge, channel 1 disabled
        clk_div_i = 6'd1; start_i = 6'd5; end_i = 6'd3; en_i = 2'b01;
        data_i = 16'hFFFF; valid_i = 1'b1;
        @(posedge clk); #2 valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("clamp_rcv_k%0d", k), 32'(rcv_clk_o), 32'h0);
            chk($sformatf("clamp_lanes_k%0d", k), 32'(lanes_o), (k >= 1 && k <= 3) ? 32'h0F : 32'h00);
            chk($sformatf("clamp_busy_k%0d", k), 32'(busy_o), (k <= 3) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #2;

        // Asynchronous reset mid-slot
        clk_div_i = 6'd4; start_i = 6'd1; end_i = 6'd3; en_i = 2'b11; ddr_i = 1'b1;
        data_i = 16'hC3A5; valid_i = 1'b1;
        @(posedge clk); #2 valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_lanes", 32'(lanes_o), 32'h35);
        chk("pre_rst_rcv", 32'(rcv_clk_o), 32'h3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_lanes", 32'(lanes_o), 32'h0);
        chk("async_rst_rcv", 32'(rcv_clk_o), 32'h0);
        chk("async_rst_busy", 32'(busy_o), 32'h0);
        chk("async_rst_bcnt", 32'(beat_cnt_o), 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;
        ddr_i = 1'b0; data_i = 16'h1234; valid_i = 1'b1;
        @(posedge clk); #2 valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_lanes", 32'(lanes_o), 32'h24);
        chk("post_rst_bcnt", 32'(beat_cnt_o), 32'd1);
        repeat (12) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
